cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit_if.sv | 32 +++
 rtl/cond_unit.sv | 87 ++++++++
 tb/tb_cond_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_unit_if.sv
// Bundles the condition unit's instruction-side inputs and gated/status outputs.
// master drives instruction/decode info; slave is the condition unit itself.
interface cond_unit_if #(
  parameter int CW = 16
);
  logic [3:0]    alu_flags;
  logic [3:0]    cond;
  logic [1:0]    flag_w;
  logic          instr_valid;
  logic          stall;
  logic          pcs;
  logic          reg_w;
  logic          mem_w;
  logic          clr_counts;
  logic          pc_src_o;
  logic          reg_w_o;
  logic          mem_w_o;
  logic          cond_ex_o;
  logic [3:0]    flags_o;
  logic [CW-1:0] exec_count;
  logic [CW-1:0] squash_count;

  modport master (
    output alu_flags, cond, flag_w, instr_valid, stall, pcs, reg_w, mem_w, clr_counts,
    input  pc_src_o, reg_w_o, mem_w_o, cond_ex_o, flags_o, exec_count, squash_count
  );

  modport slave (
    input  alu_flags, cond, flag_w, instr_valid, stall, pcs, reg_w, mem_w, clr_counts,
    output pc_src_o, reg_w_o, mem_w_o, cond_ex_o, flags_o, exec_count, squash_count
  );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution unit: evaluates cond against the registered NZCV flags,
// gates decode write enables, updates flags and counts executed/squashed instructions.
module cond_unit #(
  parameter int CW = 16
) (
  input logic       clk,
  input logic       rst,
  cond_unit_if.slave bus
);
  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] exec_q, exec_d;
  logic [CW-1:0] squash_q, squash_d;
  logic          cond_ex;
  logic          active;
  logic          go;
  logic          n, z, c, v;

  assign n = flags_q[3];
  assign z = flags_q[2];
  assign c = flags_q[1];
  assign v = flags_q[0];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cond_ex = 1'b1;
    case (bus.cond)
      4'h0:    cond_ex = z;
      4'h1:    cond_ex = !z;
      4'h2:    cond_ex = c;
      4'h3:    cond_ex = !c;
      4'h4:    cond_ex = n;
      4'h5:    cond_ex = !n;
      4'h6:    cond_ex = v;
      4'h7:    cond_ex = !v;
      4'h8:    cond_ex = c & !z;
      4'h9:    cond_ex = !c | z;
      4'hA:    cond_ex = (n == v);
      4'hB:    cond_ex = (n != v);
      4'hC:    cond_ex = !z & (n == v);
      4'hD:    cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

  assign active = bus.instr_valid & !bus.stall;
  assign go     = cond_ex & active;

  assign bus.cond_ex_o    = cond_ex;
  assign bus.pc_src_o     = bus.pcs & go;
  assign bus.reg_w_o      = bus.reg_w & go;
  assign bus.mem_w_o      = bus.mem_w & go;
  assign bus.flags_o      = flags_q;
  assign bus.exec_count   = exec_q;
  assign bus.squash_count = squash_q;

  // Squashed instructions never touch flags; N,Z and C,V pairs update independently.
  always_comb begin
    flags_d  = flags_q;
    exec_d   = exec_q;
    squash_d = squash_q;
    if (go && bus.flag_w[1]) flags_d[3:2] = bus.alu_flags[3:2];
    if (go && bus.flag_w[0]) flags_d[1:0] = bus.alu_flags[1:0];
    if (bus.clr_counts) begin
      exec_d   = '0;
      squash_d = '0;
    end else if (active) begin
      if (cond_ex) begin
        if (exec_q != {CW{1'b1}}) exec_d = exec_q + CW'(1);
      end else begin
        if (squash_q != {CW{1'b1}}) squash_d = squash_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= '0;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      flags_q  <= flags_d;
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end
endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit: a reference model feeds a scoreboard
// queue at drive time; entries are popped and compared at the following negedge.
module tb_cond_unit;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  cond_unit_if #(.CW(CW)) bus ();

  cond_unit #(.CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cex;
    logic          pc;
    logic          rw;
    logic          mw;
    logic [3:0]    fl;
    logic [CW-1:0] ex;
    logic [CW-1:0] sq;
  } exp_t;

  exp_t          sb_q[$];
  logic [3:0]    m_flags;
  logic [CW-1:0] m_exec;
  logic [CW-1:0] m_squash;

  function automatic logic m_pass(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return fz || (fn != fv);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                        input logic vld, input logic stl, input logic [2:0] wr,
                        input logic clr, input logic r);
    bus.cond        = c;
    bus.flag_w      = fw;
    bus.alu_flags   = alu;
    bus.instr_valid = vld;
    bus.stall       = stl;
    {bus.pcs, bus.reg_w, bus.mem_w} = wr;
    bus.clr_counts  = clr;
    rst             = r;
  endtask

  task automatic model_edge();
    logic p, act;
    p   = m_pass(bus.cond, m_flags);
    act = bus.instr_valid && !bus.stall;
    if (rst) begin
      m_flags  = '0;
      m_exec   = '0;
      m_squash = '0;
    end else begin
      if (p && act && bus.flag_w[1]) m_flags[3:2] = bus.alu_flags[3:2];
      if (p && act && bus.flag_w[0]) m_flags[1:0] = bus.alu_flags[1:0];
      if (bus.clr_counts) begin
        m_exec   = '0;
        m_squash = '0;
      end else if (act) begin
        if (p) begin
          if (m_exec != {CW{1'b1}}) m_exec = m_exec + 1'b1;
        end else begin
          if (m_squash != {CW{1'b1}}) m_squash = m_squash + 1'b1;
        end
      end
    end
  endtask

  // Push expectation for current inputs, compare at negedge, then advance one edge.
  task automatic tick(input string tag);
    exp_t e, got;
    logic go;
    e.cex = m_pass(bus.cond, m_flags);
    go    = e.cex && bus.instr_valid && !bus.stall;
    e.pc  = bus.pcs && go;
    e.rw  = bus.reg_w && go;
    e.mw  = bus.mem_w && go;
    e.fl  = m_flags;
    e.ex  = m_exec;
    e.sq  = m_squash;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    check({tag, ".cond_ex"}, 32'(bus.cond_ex_o),    32'(got.cex));
    check({tag, ".pc_src"},  32'(bus.pc_src_o),     32'(got.pc));
    check({tag, ".reg_w"},   32'(bus.reg_w_o),      32'(got.rw));
    check({tag, ".mem_w"},   32'(bus.mem_w_o),      32'(got.mw));
    check({tag, ".flags"},   32'(bus.flags_o),      32'(got.fl));
    check({tag, ".exec"},    32'(bus.exec_count),   32'(got.ex));
    check({tag, ".squash"},  32'(bus.squash_count), 32'(got.sq));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick_fast();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_flags = '0; m_exec = '0; m_squash = '0;
    set_in(4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    @(posedge clk); #1;
    tick_fast();
    tick("reset");
    check("reset_flags", 32'(bus.flags_o), 32'h0);
    check("reset_exec", 32'(bus.exec_count), 32'h0);

    // Squash on EQ with Z clear
    set_in(4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    #2;
    check("eq_squash_cex", 32'(bus.cond_ex_o), 32'h0);
    check("eq_squash_regw", 32'(bus.reg_w_o), 32'h0);
    tick("eq_squash");
    check("eq_squash_cnt", 32'(bus.squash_count), 32'h1);

    // AL writes Z, then EQ passes
    set_in(4'hE, 2'b11, 4'h4, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    tick("al_setz");
    check("al_setz_flags", 32'(bus.flags_o), 32'h4);
    set_in(4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    #2;
    check("eq_pass_cex", 32'(bus.cond_ex_o), 32'h1);
    tick("eq_pass");
    check("eq_pass_exec", 32'(bus.exec_count), 32'h2);

    // Partial flag write keeps N,Z
    set_in(4'hE, 2'b11, 4'h8, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    tick("set_n");
    set_in(4'hE, 2'b01, 4'h3, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    tick("cv_only");
    check("cv_only_flags", 32'(bus.flags_o), 32'hB);
    set_in(4'hA, 2'b00, 4'h0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0);
    #2;
    check("ge_pass_cex", 32'(bus.cond_ex_o), 32'h1);
    tick("ge_pass");

    // Stall blocks everything
    set_in(4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 3'b101, 1'b0, 1'b0);
    #2;
    check("stall_pc", 32'(bus.pc_src_o), 32'h0);
    check("stall_memw", 32'(bus.mem_w_o), 32'h0);
    tick("stall");
    check("stall_flags", 32'(bus.flags_o), 32'hB);

    // Squashed instruction with flag_w must not update flags; then a bubble
    set_in(4'h0, 2'b11, 4'h4, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0);
    tick("squash_fw");
    check("squash_fw_flags", 32'(bus.flags_o), 32'hB);
    set_in(4'hE, 2'b11, 4'h0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0);
    tick("bubble");

    // Decode sweep: load each flag pattern, then every condition with random enables
    for (int f = 0; f < 16; f++) begin
      set_in(4'hE, 2'b11, 4'(f), 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      tick("load_flags");
      for (int c = 0; c < 16; c++) begin
        set_in(4'(c), 2'b00, 4'($urandom), 1'b1, 1'($urandom_range(0, 3) == 0),
               3'($urandom), 1'b0, 1'b0);
        tick("sweep");
      end
    end

    // Saturation of exec_count
    set_in(4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    tick("clear");
    check("clear_exec", 32'(bus.exec_count), 32'h0);
    set_in(4'hE, 2'b00, 4'h0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) tick_fast();
    check("preload_exec", 32'(bus.exec_count), 32'hFFFF);
    tick("sat");
    check("sat_exec", 32'(bus.exec_count), 32'hFFFF);
    set_in(4'hE, 2'b00, 4'h0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    tick("clr_override");
    check("clr_override_exec", 32'(bus.exec_count), 32'h0);

    // Reset overrides a same-edge flag write
    set_in(4'hE, 2'b11, 4'h4, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    tick("pre_rst");
    set_in(4'h0, 2'b11, 4'h0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1);
    #2;
    check("rst_gated_regw", 32'(bus.reg_w_o), 32'h1);
    tick("mid_rst");
    check("mid_rst_flags", 32'(bus.flags_o), 32'h0);
    check("mid_rst_exec", 32'(bus.exec_count), 32'h0);

    // First go after reset takes effect immediately
    set_in(4'hE, 2'b11, 4'hF, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    tick("post_rst");
    check("post_rst_flags", 32'(bus.flags_o), 32'hF);
    check("post_rst_exec", 32'(bus.exec_count), 32'h1);
    set_in(4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    tick("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
